// File: rtl/demux_5bit_buffered.sv
// demux_5bit_buffered: routes a 5-bit word to one of four holding registers
// (J/K/L/M) selected directly by S or by an internal round-robin pointer.
// Each channel is a one-deep buffer with a valid/ready handshake that
// sustains one word per cycle when the consumer drains as the producer loads.
module demux_5bit_buffered (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] S,
  input  logic       rr_mode,
  output logic [4:0] J,
  output logic [4:0] K,
  output logic [4:0] L,
  output logic [4:0] M,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [7:0] xfer_count
);

  // Channel storage: index 0..3 maps to J..M.
  logic [3:0][4:0] chan_q, chan_d;
  logic [3:0]      valid_q, valid_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      xfer_count_q, xfer_count_d;

  logic [1:0]      dst_s;
  logic            ready_s;
  logic            accept_s;

  // Destination select and handshake; in_ready depends only on state and
  // the select/ready inputs, never on D.
  always_comb begin
    dst_s    = 2'd0;
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if (rr_mode) begin
      dst_s = rr_ptr_q;
    end else begin
      dst_s = S;
    end
    ready_s  = (~valid_q[dst_s]) | out_ready[dst_s];
    accept_s = in_valid & ready_s;
  end

  // Next-state: load on accept (wins over drain), else clear valid on drain.
  always_comb begin
    chan_d       = chan_q;
    valid_d      = valid_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q;
    for (int n = 0; n < 4; n++) begin
      if (accept_s && (dst_s == n[1:0])) begin
        chan_d[n]  = D;
        valid_d[n] = 1'b1;
      end else if (out_ready[n]) begin
        valid_d[n] = 1'b0;
      end else begin
        valid_d[n] = valid_q[n];
      end
    end
    if (accept_s) begin
      xfer_count_d = xfer_count_q + 8'd1;
      if (rr_mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      xfer_count_d = xfer_count_q;
      rr_ptr_d     = rr_ptr_q;
    end
  end

  // State registers with synchronous reset overriding any accept or drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chan_q       <= '0;
      valid_q      <= 4'b0000;
      rr_ptr_q     <= 2'd0;
      xfer_count_q <= 8'd0;
    end else begin
      chan_q       <= chan_d;
      valid_q      <= valid_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign in_ready   = ready_s;
  assign J          = chan_q[0];
  assign K          = chan_q[1];
  assign L          = chan_q[2];
  assign M          = chan_q[3];
  assign out_valid  = valid_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_demux_5bit_buffered.sv
// Directed self-checking bench for demux_5bit_buffered.
module tb_demux_5bit_buffered;

  logic       clk;
  logic       reset;
  logic [4:0] D;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] S;
  logic       rr_mode;
  logic [4:0] J, K, L, M;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_count;

  int n_cmp = 0;
  int n_err = 0;

  demux_5bit_buffered dut (
    .clk(clk), .reset(reset), .D(D), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .rr_mode(rr_mode), .J(J), .K(K), .L(L), .M(M),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; D = 5'd0; in_valid = 1'b0; S = 2'd0; rr_mode = 1'b0; out_ready = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_J", J, 5'h00);
    chk("rst_K", K, 5'h00);
    chk("rst_L", L, 5'h00);
    chk("rst_M", M, 5'h00);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_xfer", xfer_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed select into L.
    S = 2'b10; D = 5'h15; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sel_L", L, 5'h15);
    chk("sel_out_valid", out_valid, 4'b0100);
    chk("sel_J", J, 5'h00);
    chk("sel_K", K, 5'h00);
    chk("sel_M", M, 5'h00);
    chk("sel_xfer", xfer_count, 8'd1);

    // Backpressure: L full and not draining.
    S = 2'b10; D = 5'h07; in_valid = 1'b1; out_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_lo", in_ready, 1'b0);
      tick();
      chk("bp_L_hold", L, 5'h15);
      chk("bp_xfer_hold", xfer_count, 8'd1);
    end
    out_ready = 4'b0100;
    #1;
    chk("bp_in_ready_hi", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("bp_L_new", L, 5'h07);
    chk("bp_valid2", out_valid[2], 1'b1);
    chk("bp_xfer", xfer_count, 8'd2);

    // Drain L; register keeps its value, ready with no valid has no effect on others.
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    chk("drain_valid", out_valid, 4'b0000);
    chk("drain_L_keep", L, 5'h07);

    // Round-robin wrap from a fresh reset.
    do_reset();
    rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      D = 5'(i);
      tick();
    end
    chk("rr_J", J, 5'd5);
    chk("rr_K", K, 5'd2);
    chk("rr_L", L, 5'd3);
    chk("rr_M", M, 5'd4);
    chk("rr_xfer", xfer_count, 8'd5);
    chk("rr_valid", out_valid, 4'b0001);
    // Pointer now at 1: next word lands in K.
    out_ready = 4'b0000; D = 5'd6;
    tick();
    in_valid = 1'b0;
    chk("rr_ptr1_K", K, 5'd6);
    chk("rr_ptr1_valid", out_valid, 4'b0011);
    chk("rr_ptr1_xfer", xfer_count, 8'd6);

    // Mode switching holds the pointer.
    do_reset();
    rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    D = 5'h0A; tick();
    D = 5'h0B; tick();
    rr_mode = 1'b0; S = 2'b11; D = 5'h0C; tick();
    rr_mode = 1'b1; D = 5'h0D; tick();
    in_valid = 1'b0;
    chk("mode_J", J, 5'h0A);
    chk("mode_K", K, 5'h0B);
    chk("mode_M", M, 5'h0C);
    chk("mode_L", L, 5'h0D);
    chk("mode_xfer", xfer_count, 8'd4);

    // Simultaneous drain and load on K.
    rr_mode = 1'b0; S = 2'b01; out_ready = 4'b0000; D = 5'h11; in_valid = 1'b1;
    tick();
    chk("dl_K_first", K, 5'h11);
    chk("dl_valid_first", out_valid[1], 1'b1);
    out_ready = 4'b0010; D = 5'h12;
    #1;
    chk("dl_in_ready", in_ready, 1'b1);
    tick();
    chk("dl_K_second", K, 5'h12);
    chk("dl_valid_second", out_valid[1], 1'b1);
    D = 5'h13;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("dl_K_third", K, 5'h13);
    chk("dl_valid_third", out_valid[1], 1'b1);
    chk("dl_xfer", xfer_count, 8'd7);

    // Fill all four channels, bring count to 200, then reset mid-stream.
    do_reset();
    rr_mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S = 2'(i); D = 5'(5'h1C + i);
      tick();
    end
    S = 2'b00; out_ready = 4'b0001;
    for (int i = 0; i < 196; i++) begin
      D = 5'(i);
      tick();
    end
    out_ready = 4'b0000;
    chk("pre_rst_xfer", xfer_count, 8'd200);
    chk("pre_rst_valid", out_valid, 4'b1111);
    reset = 1'b1; in_valid = 1'b1; D = 5'h1F;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_rst_J", J, 5'h00);
    chk("mid_rst_K", K, 5'h00);
    chk("mid_rst_L", L, 5'h00);
    chk("mid_rst_M", M, 5'h00);
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_xfer", xfer_count, 8'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    tick();
    chk("mid_rst_valid_stays", out_valid, 4'b0000);

    // 256 accepts wrap the transfer counter.
    rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      D = 5'(i);
      tick();
    end
    chk("wrap_xfer_255", xfer_count, 8'd255);
    D = 5'h1F;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("wrap_xfer_0", xfer_count, 8'd0);
    chk("wrap_M", M, 5'h1F);
    chk("wrap_valid", out_valid, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
